// File: rtl/aq_spsram_pkg.sv
// aq_spsram_pkg: shared state encoding, depth derivation and inactive levels for the single-port SRAM controls
package aq_spsram_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_e;
  localparam logic CEN_OFF     = 1'b1;
  localparam logic GWEN_OFF    = 1'b1;
  localparam logic WEN_OFF_BIT = 1'b1;
  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction
endpackage

// File: rtl/aq_spsram_acc_ctrl_if.sv
// aq_spsram_acc_ctrl_if: request/response/clear channel plus the SRAM macro pins
interface aq_spsram_acc_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  init_req;
  logic                  init_busy;
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;
  modport master (
    output req_vld, req_write, req_addr, req_wdata, req_wmask, rsp_rdy, init_req,
    input  req_rdy, rsp_vld, rsp_rdata, init_busy, init_done
  );
  modport slave (
    input  req_vld, req_write, req_addr, req_wdata, req_wmask, rsp_rdy, init_req, sram_q,
    output req_rdy, rsp_vld, rsp_rdata, init_busy, init_done,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );
  modport mem (
    input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d,
    output sram_q
  );
endinterface

// File: rtl/aq_spsram_rsp_hold.sv
// aq_spsram_rsp_hold: one-entry skid register keeping SRAM read data while the consumer stalls
module aq_spsram_rsp_hold #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  rd_pend_i,
  input  logic                  rsp_rdy_i,
  input  logic [DATA_WIDTH-1:0] sram_q_i,
  output logic                  rsp_vld_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  hold_vld_o
);
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  capture;
  // SRAM Q is only valid for one cycle, so a stalled read must be parked here
  assign capture     = rd_pend_i & ~rsp_rdy_i & ~hold_vld_q;
  assign hold_vld_d  = hold_vld_q ? ~rsp_rdy_i : capture;
  assign hold_data_d = capture ? sram_q_i : hold_data_q;
  assign rsp_vld_o   = rd_pend_i | hold_vld_q;
  assign rsp_rdata_o = hold_vld_q ? hold_data_q : sram_q_i;
  assign hold_vld_o  = hold_vld_q;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end
endmodule

// File: rtl/aq_spsram_acc_ctrl.sv
// aq_spsram_acc_ctrl: valid/ready request/response front-end and zeroing sequencer for a single-port SRAM macro
module aq_spsram_acc_ctrl
  import aq_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 32,
  parameter bit INIT_ON_RST = 1'b1
) (
  input logic                 forever_cpuclk,
  input logic                 cpurst_b,
  aq_spsram_acc_ctrl_if.slave bus
);
  localparam int unsigned           DEPTH   = depth_of(unsigned'(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] WEN_OFF = {DATA_WIDTH{WEN_OFF_BIT}};
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init_pend_q, init_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  in_init, cnt_last, xfer, wr, hold_vld, rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  assign in_init  = state_q == INIT;
  assign cnt_last = cnt_q == LAST;
  // cpurst_b gating keeps the SRAM pins idle while reset is held, even with no pending clear
  assign bus.req_rdy = cpurst_b & ~in_init & ~init_pend_q & ~hold_vld & ~(rd_pend_q & ~bus.rsp_rdy);
  assign xfer        = bus.req_vld & bus.req_rdy;
  assign wr          = xfer & bus.req_write;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      init_pend_q <= INIT_ON_RST;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_pend_q <= init_pend_d;
      rd_pend_q   <= rd_pend_d;
    end
  end
  always_comb begin
    state_d     = in_init ? (cnt_last ? IDLE : INIT) : (init_pend_q ? INIT : IDLE);
    cnt_d       = in_init ? cnt_q + ADDR_WIDTH'(1) : '0;
    init_pend_d = (in_init & cnt_last) ? 1'b0 : init_pend_q | (~in_init & bus.init_req);
    rd_pend_d   = xfer & ~bus.req_write;
  end
  always_comb begin
    bus.init_busy = init_pend_q | in_init;
    bus.init_done = in_init & cnt_last;
    bus.sram_cen  = (in_init | xfer) ? ~CEN_OFF : CEN_OFF;
    bus.sram_gwen = (in_init | wr) ? ~GWEN_OFF : GWEN_OFF;
    bus.sram_wen  = in_init ? ~WEN_OFF : wr ? ~bus.req_wmask : WEN_OFF;
    bus.sram_a    = in_init ? cnt_q : xfer ? bus.req_addr : '0;
    bus.sram_d    = wr ? bus.req_wdata : '0;
    bus.rsp_vld   = rsp_vld;
    bus.rsp_rdata = rsp_rdata;
  end
  aq_spsram_rsp_hold #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_hold (
    .forever_cpuclk(forever_cpuclk),
    .cpurst_b      (cpurst_b),
    .rd_pend_i     (rd_pend_q),
    .rsp_rdy_i     (bus.rsp_rdy),
    .sram_q_i      (bus.sram_q),
    .rsp_vld_o     (rsp_vld),
    .rsp_rdata_o   (rsp_rdata),
    .hold_vld_o    (hold_vld)
  );
endmodule

// File: doc/aq_spsram_acc_ctrl.md
Name: aq_spsram_acc_ctrl

Overview:
- Initiator side of the single-port SRAM macro interface: A, CEN, GWEN, WEN, D, Q.
- Converts a valid/ready request channel and a valid/ready read-response channel into SRAM cycles, and drives those cycles into an aq_spsram_2048x32-class wrapper.
- Owns a hardware clear sequencer that zeroes every entry after reset or on request.
- Used by IFU-side buffers (predictor/tag arrays) that need a zeroed RAM and back-pressurable reads.

Parameters:
- ADDR_WIDTH, 11, SRAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, SRAM data width; WEN is also DATA_WIDTH bits.
- INIT_ON_RST, 1, when 1 a clear pass starts automatically after reset.

Ports:
- forever_cpuclk  in  1  clock; also drives the SRAM CLK.
- cpurst_b  in  1  asynchronous active-low reset.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; a request transfers when req_vld & req_rdy.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  active-high bit write mask.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_req  in  1  pulse; requests a full clear pass.
- init_busy  out  1  clear pass pending or in progress.
- init_done  out  1  one-cycle pulse, asserted on the cycle the last clear write issues.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN, active-low chip enable.
- sram_gwen  out  1  to SRAM GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low bit write enables.
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_q  in  DATA_WIDTH  from SRAM Q; valid the cycle after a read.

Behaviour:
- Clock/reset: one clock, forever_cpuclk. Reset cpurst_b is asynchronous and active-low.
- State machine: states IDLE and INIT. Reset values:
  - state = IDLE, cnt = 0.
  - init_pend = INIT_ON_RST, rd_pend = 0, hold_vld = 0, hold_data = 0.
- SRAM drive is combinational from state and the handshake, so the SRAM samples at the next edge.
  - Idle (no access) values: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
  - These idle values also hold throughout reset.
- IDLE:
  - req_rdy = ~init_pend & ~hold_vld & ~(rd_pend & ~rsp_rdy).
  - On a transfer:
    - sram_cen = 0, sram_a = req_addr.
    - Write: sram_gwen = 0, sram_wen = ~req_wmask, sram_d = req_wdata.
    - Read: sram_gwen = 1, sram_wen = all 1, sram_d = 0.
  - A write with req_wmask = 0 still issues the cycle; no bits change.
  - Writes produce no response.
- Read pipeline:
  - An accepted read sets rd_pend for the next cycle.
  - rsp_vld = rd_pend | hold_vld.
  - rsp_rdata = hold_vld ? hold_data : sram_q.
  - If rd_pend & ~rsp_rdy: capture sram_q into hold_data and set hold_vld.
  - hold_vld clears on rsp_vld & rsp_rdy.
- Throughput and latency:
  - Back-to-back reads sustain 1 per cycle while rsp_rdy = 1.
  - Read latency is 1 cycle: request accepted at edge N, rsp_vld high in cycle N+1.
- Leaving IDLE for INIT: when state = IDLE and init_pend = 1, go to INIT with cnt = 0. An outstanding rd_pend/hold response completes normally; its data is already captured.
- INIT, every cycle:
  - Drive sram_cen = 0, sram_gwen = 0, sram_wen = all 0, sram_a = cnt, sram_d = 0.
  - Increment cnt; req_rdy = 0.
  - When cnt = DEPTH-1: pulse init_done, clear init_pend, go to IDLE.
- Clear pass length: exactly DEPTH cycles in INIT.
- init_busy = init_pend | (state == INIT).
- init_req handling:
  - In IDLE: sets init_pend at the next edge. A request accepted in the same cycle as init_req still completes.
  - In INIT: ignored, with no restart.
- cnt width is ADDR_WIDTH; it wraps to 0 naturally after DEPTH-1.
- Reset asserted mid-INIT or mid-read: everything returns to reset values at once. Pending responses are dropped, and the clear restarts from 0 if INIT_ON_RST = 1.
- rsp_vld is never asserted for writes or for clear cycles.

Decomposition:
- Shared package aq_spsram_pkg holds:
  - state encoding: IDLE = 1'b0, INIT = 1'b1;
  - the DEPTH derivation;
  - the active-low idle constants for CEN/GWEN/WEN.
- One natural sub-module: aq_spsram_rsp_hold, the one-entry response hold register with its valid/ready logic. The FSM and SRAM drive stay in the top level.

Test Plan:
- Reset with INIT_ON_RST = 1:
  - 1 idle cycle, then 2048 cycles with sram_cen = 0, sram_gwen = 0, sram_a = 0..2047, sram_d = 0.
  - init_done pulses with sram_a = 2047; req_rdy rises the next cycle.
- Write 0xDEADBEEF to addr 0x155 with wmask 0xFFFFFFFF, then write 0x00000000 with wmask 0x0000FFFF, then read 0x155 → sram_wen = 0xFFFF0000 on the second write; rsp_rdata = 0xDEAD0000 exactly one cycle after read acceptance.
- 4 back-to-back reads of addrs 0..3 holding 0x10..0x13 with rsp_rdy = 1 → rsp_vld high 4 consecutive cycles, data 0x10..0x13 in order, req_rdy never drops.
- Read addr 7 (data 0x77) with rsp_rdy held 0 for 3 cycles:
  - hold_vld set and req_rdy = 0 throughout;
  - rsp_rdata stays 0x77 while a different-address sram_q toggles;
  - one transfer when rsp_rdy rises.
- init_req pulsed in the same cycle as an accepted write to addr 9 (data 0x5A):
  - write issues, then a full 2048-cycle clear follows;
  - a subsequent read of addr 9 returns 0;
  - a second init_req mid-INIT does not lengthen the pass.
- cpurst_b asserted at cycle 500 of INIT → all SRAM outputs go to their idle values at once, rsp_vld = 0; after release the clear restarts at sram_a = 0.
